// File: rtl/wb_grf_writer_if.sv
// Bus bundle for wb_grf_writer: main M->W result, auxiliary write request,
// and the registered register-file write port with the pending-write mask.
interface wb_grf_writer_if;
  logic        m_we;
  logic [4:0]  m_a3;
  logic [31:0] m_wd;
  logic [31:0] m_pc;

  logic        aux_req;
  logic [4:0]  aux_a3;
  logic [31:0] aux_wd;
  logic [31:0] aux_pc;
  logic        aux_ready;

  logic        grf_we;
  logic [4:0]  grf_a3;
  logic [31:0] grf_wd;
  logic [31:0] grf_pc;
  logic [31:0] pending_mask;

  modport master (
    output m_we, m_a3, m_wd, m_pc,
    output aux_req, aux_a3, aux_wd, aux_pc,
    input  aux_ready,
    input  grf_we, grf_a3, grf_wd, grf_pc, pending_mask
  );

  modport slave (
    input  m_we, m_a3, m_wd, m_pc,
    input  aux_req, aux_a3, aux_wd, aux_pc,
    output aux_ready,
    output grf_we, grf_a3, grf_wd, grf_pc, pending_mask
  );
endinterface

// File: rtl/wb_grf_writer.sv
// Write-back driver for the register-file write port: main results win, aux results queue and drain into idle cycles.
// Optional macro WB_TRACE_EN prints a judge-format trace line for every non-zero register write.
module wb_grf_writer #(
  parameter int AUX_DEPTH = 2,
  parameter int CNT_W     = 4
) (
  input logic            clk,
  input logic            reset,
  wb_grf_writer_if.slave wb
);
  localparam int PTR_W = (AUX_DEPTH > 1) ? $clog2(AUX_DEPTH) : 1;

  logic [4:0]           r_a3 [AUX_DEPTH];
  logic [31:0]          r_wd [AUX_DEPTH];
  logic [31:0]          r_pc [AUX_DEPTH];
  logic [AUX_DEPTH-1:0] r_valid;
  logic [PTR_W-1:0]     r_head;
  logic [PTR_W-1:0]     r_tail;
  logic [CNT_W-1:0]     r_count;

  logic        r_grf_we;
  logic [4:0]  r_grf_a3;
  logic [31:0] r_grf_wd;
  logic [31:0] r_grf_pc;

  logic                 w_mw;
  logic                 w_ready;
  logic                 w_push;
  logic                 w_pop;
  logic [AUX_DEPTH-1:0] w_kill;
  logic [31:0]          w_mask;
  logic [PTR_W-1:0]     w_head_next;
  logic [PTR_W-1:0]     w_tail_next;

  assign w_mw    = wb.m_we && (wb.m_a3 != 5'd0);
  assign w_ready = (r_count < CNT_W'(AUX_DEPTH));
  // Writes to r0 complete the handshake but occupy no slot.
  assign w_push  = wb.aux_req && w_ready && (wb.aux_a3 != 5'd0);
  assign w_pop   = !w_mw && (r_count != '0);

  assign w_head_next = (r_head == PTR_W'(AUX_DEPTH - 1)) ? '0 : r_head + 1'b1;
  assign w_tail_next = (r_tail == PTR_W'(AUX_DEPTH - 1)) ? '0 : r_tail + 1'b1;

  generate
    for (genvar gi = 0; gi < AUX_DEPTH; gi++) begin : g_slot
      assign w_kill[gi] = w_mw && r_valid[gi] && (r_a3[gi] == wb.m_a3);

      always_ff @(posedge clk) begin
        if (w_push && (r_tail == PTR_W'(gi))) begin
          r_a3[gi] <= wb.aux_a3;
          r_wd[gi] <= wb.aux_wd;
          r_pc[gi] <= wb.aux_pc;
        end
      end

      // A killed entry keeps its slot; it is simply no longer valid.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_valid[gi] <= 1'b0;
        end else if (w_push && (r_tail == PTR_W'(gi))) begin
          r_valid[gi] <= 1'b1;
        end else if (w_pop && (r_head == PTR_W'(gi))) begin
          r_valid[gi] <= 1'b0;
        end else if (w_kill[gi]) begin
          r_valid[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
      if (w_pop) begin
        r_head <= w_head_next;
      end
      if (w_push) begin
        r_tail <= w_tail_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_grf_we <= 1'b0;
      r_grf_a3 <= '0;
      r_grf_wd <= '0;
      r_grf_pc <= '0;
    end else if (w_mw) begin
      r_grf_we <= 1'b1;
      r_grf_a3 <= wb.m_a3;
      r_grf_wd <= wb.m_wd;
      r_grf_pc <= wb.m_pc;
    end else if (w_pop && r_valid[r_head]) begin
      r_grf_we <= 1'b1;
      r_grf_a3 <= r_a3[r_head];
      r_grf_wd <= r_wd[r_head];
      r_grf_pc <= r_pc[r_head];
    end else begin
      r_grf_we <= 1'b0;
      r_grf_a3 <= '0;
      r_grf_wd <= '0;
      r_grf_pc <= '0;
    end
  end

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < AUX_DEPTH; i++) begin
      if (r_valid[i]) begin
        w_mask[r_a3[i]] = 1'b1;
      end
    end
    w_mask[0] = 1'b0;
  end

  assign wb.aux_ready    = w_ready;
  assign wb.grf_we       = r_grf_we;
  assign wb.grf_a3       = r_grf_a3;
  assign wb.grf_wd       = r_grf_wd;
  assign wb.grf_pc       = r_grf_pc;
  assign wb.pending_mask = w_mask;

`ifdef WB_TRACE_EN
  always @(posedge clk) begin
    if (r_grf_we && (r_grf_a3 != 5'd0)) begin
      $display("%d@%h: $%d <= %h", $time, r_grf_pc, r_grf_a3, r_grf_wd);
    end
  end
`endif

endmodule

// File: tb/tb_wb_grf_writer.sv
// Scoreboard bench for wb_grf_writer: stimulus queues expected register writes,
// a negedge monitor compares every asserted grf_we against the queue head.
module tb_wb_grf_writer;
  typedef struct packed {
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] pc;
  } wr_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  wr_t  exp_q[$];

  wb_grf_writer_if bus ();

  wb_grf_writer #(.AUX_DEPTH(2), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .wb    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [68:0] act, input logic [68:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [4:0] a3, input logic [31:0] wd, input logic [31:0] pc);
    wr_t w;
    w.a3 = a3;
    w.wd = wd;
    w.pc = pc;
    exp_q.push_back(w);
  endtask

  task automatic main_in(input logic we, input logic [4:0] a3, input logic [31:0] wd, input logic [31:0] pc);
    bus.m_we = we;
    bus.m_a3 = a3;
    bus.m_wd = wd;
    bus.m_pc = pc;
  endtask

  task automatic aux_in(input logic req, input logic [4:0] a3, input logic [31:0] wd, input logic [31:0] pc);
    bus.aux_req = req;
    bus.aux_a3  = a3;
    bus.aux_wd  = wd;
    bus.aux_pc  = pc;
  endtask

  // Monitor: every register write must match the oldest expected write.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.grf_we === 1'b1) begin
        wr_t act;
        act.a3 = bus.grf_a3;
        act.wd = bus.grf_wd;
        act.pc = bus.grf_pc;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_write: got a3=%0d wd=%h pc=%h required none", act.a3, act.wd, act.pc);
        end else begin
          chk("grf_write", {4'd0, act}, {4'd0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    main_in(1'b0, 5'd0, 32'd0, 32'd0);
    aux_in(1'b0, 5'd0, 32'd0, 32'd0);

    // Reset with a request held high: request must be dropped.
    reset = 1'b1;
    aux_in(1'b1, 5'd7, 32'h7777, 32'h3004);
    tick();
    tick();
    chk("rst_grf_we", 69'(bus.grf_we), 69'd0);
    chk("rst_mask", 69'(bus.pending_mask), 69'd0);
    chk("rst_ready", 69'(bus.aux_ready), 69'd1);
    reset = 1'b0;
    aux_in(1'b0, 5'd0, 32'd0, 32'd0);
    tick();
    chk("post_rst_mask", 69'(bus.pending_mask), 69'd0);
    tick();
    chk("post_rst_we", 69'(bus.grf_we), 69'd0);

    // Main pass-through, then main write to r0 is suppressed.
    main_in(1'b1, 5'd5, 32'h1234, 32'h3000);
    expect_wr(5'd5, 32'h1234, 32'h3000);
    tick();
    chk("main_we", 69'(bus.grf_we), 69'd1);
    main_in(1'b1, 5'd0, 32'hDEAD, 32'h3004);
    tick();
    chk("main_r0_we", 69'(bus.grf_we), 69'd0);
    main_in(1'b0, 5'd0, 32'd0, 32'd0);

    // Aux drain into an idle port.
    aux_in(1'b1, 5'd8, 32'hABCD, 32'h3010);
    expect_wr(5'd8, 32'hABCD, 32'h3010);
    tick();
    aux_in(1'b0, 5'd0, 32'd0, 32'd0);
    chk("aux_mask_set", 69'(bus.pending_mask), 69'(32'h0000_0100));
    tick();
    chk("aux_drain_we", 69'(bus.grf_we), 69'd1);
    chk("aux_mask_clr", 69'(bus.pending_mask), 69'd0);

    // Aux write to r0: accepted, not stored, never written.
    aux_in(1'b1, 5'd0, 32'h5555, 32'h3014);
    tick();
    aux_in(1'b0, 5'd0, 32'd0, 32'd0);
    chk("aux_r0_mask", 69'(bus.pending_mask), 69'd0);
    chk("aux_r0_ready", 69'(bus.aux_ready), 69'd1);
    tick();
    chk("aux_r0_we", 69'(bus.grf_we), 69'd0);

    // Fill FIFO while main holds the port; third request refused.
    main_in(1'b1, 5'd10, 32'h100, 32'h3020);
    aux_in(1'b1, 5'd3, 32'h33, 32'h3100);
    expect_wr(5'd10, 32'h100, 32'h3020);
    tick();
    main_in(1'b1, 5'd11, 32'h101, 32'h3024);
    aux_in(1'b1, 5'd4, 32'h44, 32'h3104);
    expect_wr(5'd11, 32'h101, 32'h3024);
    tick();
    chk("full_ready", 69'(bus.aux_ready), 69'd0);
    chk("full_mask", 69'(bus.pending_mask), 69'(32'h0000_0018));
    main_in(1'b1, 5'd12, 32'h102, 32'h3028);
    aux_in(1'b1, 5'd6, 32'h66, 32'h3108);
    expect_wr(5'd12, 32'h102, 32'h3028);
    expect_wr(5'd3, 32'h33, 32'h3100);
    expect_wr(5'd4, 32'h44, 32'h3104);
    tick();
    main_in(1'b0, 5'd0, 32'd0, 32'd0);
    aux_in(1'b0, 5'd0, 32'd0, 32'd0);
    chk("full_mask_hold", 69'(bus.pending_mask), 69'(32'h0000_0018));
    tick();
    chk("drain1_a3", 69'(bus.grf_a3), 69'd3);
    tick();
    chk("drain2_a3", 69'(bus.grf_a3), 69'd4);
    tick();
    chk("drain_done_we", 69'(bus.grf_we), 69'd0);
    chk("drain_done_mask", 69'(bus.pending_mask), 69'd0);

    // WAW kill: later main write to r9 cancels queued aux r9.
    aux_in(1'b1, 5'd9, 32'h99, 32'h3200);
    tick();
    aux_in(1'b0, 5'd0, 32'd0, 32'd0);
    chk("waw_mask_set", 69'(bus.pending_mask), 69'(32'h0000_0200));
    main_in(1'b1, 5'd9, 32'h11, 32'h3300);
    expect_wr(5'd9, 32'h11, 32'h3300);
    tick();
    main_in(1'b0, 5'd0, 32'd0, 32'd0);
    chk("waw_mask_clr", 69'(bus.pending_mask), 69'd0);
    chk("waw_ready", 69'(bus.aux_ready), 69'd1);
    tick();
    chk("waw_idle_we", 69'(bus.grf_we), 69'd0);

    // Same-edge aux push to main's register survives.
    main_in(1'b1, 5'd15, 32'h51, 32'h3400);
    aux_in(1'b1, 5'd15, 32'h52, 32'h3404);
    expect_wr(5'd15, 32'h51, 32'h3400);
    expect_wr(5'd15, 32'h52, 32'h3404);
    tick();
    main_in(1'b0, 5'd0, 32'd0, 32'd0);
    aux_in(1'b0, 5'd0, 32'd0, 32'd0);
    chk("same_edge_mask", 69'(bus.pending_mask), 69'(32'h0000_8000));
    tick();
    chk("same_edge_mask_clr", 69'(bus.pending_mask), 69'd0);

    // Reset mid-operation with two queued entries.
    main_in(1'b1, 5'd20, 32'h200, 32'h3500);
    aux_in(1'b1, 5'd13, 32'hD13, 32'h3600);
    expect_wr(5'd20, 32'h200, 32'h3500);
    tick();
    main_in(1'b1, 5'd21, 32'h201, 32'h3504);
    aux_in(1'b1, 5'd14, 32'hD14, 32'h3604);
    expect_wr(5'd21, 32'h201, 32'h3504);
    tick();
    chk("mid_mask", 69'(bus.pending_mask), 69'(32'h0000_6000));
    main_in(1'b0, 5'd0, 32'd0, 32'd0);
    aux_in(1'b0, 5'd0, 32'd0, 32'd0);
    reset = 1'b1;
    tick();
    chk("mid_rst_mask", 69'(bus.pending_mask), 69'd0);
    chk("mid_rst_ready", 69'(bus.aux_ready), 69'd1);
    chk("mid_rst_we", 69'(bus.grf_we), 69'd0);
    reset = 1'b0;
    tick();
    tick();
    tick();
    chk("mid_post_we", 69'(bus.grf_we), 69'd0);
    chk("exp_q_empty", 69'(exp_q.size()), 69'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
